// File: rtl/fpdiv_ctrl.sv
// Purpose : start/done sequencer that drives the fpdiv Goldschmidt datapath controls.
// Latency : start sampled in IDLE -> done pulses 4+2*ITERS cycles later; back in IDLE one cycle after.
// Backpres: none; start is ignored while busy (no queuing). A new request is taken only from IDLE.
//
// Ports   : clk, reset (sync, active-low), start, [abort], busy, done,
//           sel_mux4/sel_mux3/en_a/en_b/en_rem (one-to-one to fpdiv), iter (debug).
// Option  : define FPDIV_CTRL_ABORT_EN to add the abort input (busy-state cancel, no done).
module fpdiv_ctrl #(
    parameter int ITERS = 6,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          reset,
`ifdef FPDIV_CTRL_ABORT_EN
    input  logic          abort,
`endif
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [1:0]    sel_mux4,
    output logic [1:0]    sel_mux3,
    output logic          en_a,
    output logic          en_b,
    output logic          en_rem,
    output logic [CW-1:0] iter
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_N = 3'd1,
        S_LOAD_D = 3'd2,
        S_IT_A   = 3'd3,
        S_IT_B   = 3'd4,
        S_REM    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [CW-1:0] ITERS_C = CW'(ITERS);
    localparam logic [CW:0]   ITERS_W = (CW + 1)'(ITERS);

    state_t        state_q, state_d;
    logic [CW-1:0] iter_q, iter_d;
    logic [CW:0]   iter_inc;

    // Compare against ITERS one bit wider so iter+1 can never wrap.
    assign iter_inc = {1'b0, iter_q} + {{CW{1'b0}}, 1'b1};

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LOAD_N;
            S_LOAD_N: state_d = S_LOAD_D;
            S_LOAD_D: state_d = S_IT_A;
            S_IT_A:   state_d = S_IT_B;
            S_IT_B: begin
                // Saturate rather than wrap in case of an unexpected extra pass.
                iter_d  = (iter_q == ITERS_C) ? iter_q : iter_inc[CW-1:0];
                state_d = (iter_inc < ITERS_W) ? S_IT_A : S_REM;
            end
            S_REM:    state_d = S_DONE;
            S_DONE: begin
                state_d = S_IDLE;
                iter_d  = '0;
            end
            default: begin
                // Unused encoding: recover to a clean IDLE.
                state_d = S_IDLE;
                iter_d  = '0;
            end
        endcase
`ifdef FPDIV_CTRL_ABORT_EN
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            iter_d  = '0;
        end
`endif
    end

    // Moore output decode
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        sel_mux4 = 2'b00;
        sel_mux3 = 2'b00;
        en_a     = 1'b0;
        en_b     = 1'b0;
        en_rem   = 1'b0;
        case (state_q)
            S_IDLE: ;
            S_LOAD_N: begin
                busy = 1'b1;
                en_a = 1'b1;
            end
            S_LOAD_D: begin
                busy     = 1'b1;
                sel_mux4 = 2'b01;
                en_b     = 1'b1;
            end
            S_IT_A: begin
                busy     = 1'b1;
                sel_mux4 = 2'b10;
                sel_mux3 = 2'b01;
                en_a     = 1'b1;
            end
            S_IT_B: begin
                busy     = 1'b1;
                sel_mux4 = 2'b11;
                sel_mux3 = 2'b01;
                en_b     = 1'b1;
            end
            S_REM: begin
                busy     = 1'b1;
                sel_mux4 = 2'b01;
                sel_mux3 = 2'b10;
                en_rem   = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign iter = iter_q;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Purpose : directed self-checking bench for fpdiv_ctrl (ITERS=6 main DUT, ITERS=1 side DUT).
// Latency : expected per-cycle outputs derived from the cycle index after start is sampled.
// Backpres: n/a.
module tb_fpdiv_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, start1;
`ifdef FPDIV_CTRL_ABORT_EN
    logic       abort;
`endif
    logic       busy, done, en_a, en_b, en_rem;
    logic [1:0] sel_mux4, sel_mux3;
    logic [3:0] iter;
    logic       busy1, done1, en_a1, en_b1, en_rem1;
    logic [1:0] sel_mux4_1, sel_mux3_1;
    logic [3:0] iter1;

    fpdiv_ctrl #(.ITERS(6), .CW(4)) u_dut (
        .clk(clk), .reset(reset),
`ifdef FPDIV_CTRL_ABORT_EN
        .abort(abort),
`endif
        .start(start), .busy(busy), .done(done),
        .sel_mux4(sel_mux4), .sel_mux3(sel_mux3),
        .en_a(en_a), .en_b(en_b), .en_rem(en_rem), .iter(iter)
    );

    fpdiv_ctrl #(.ITERS(1), .CW(4)) u_dut1 (
        .clk(clk), .reset(reset),
`ifdef FPDIV_CTRL_ABORT_EN
        .abort(1'b0),
`endif
        .start(start1), .busy(busy1), .done(done1),
        .sel_mux4(sel_mux4_1), .sel_mux3(sel_mux3_1),
        .en_a(en_a1), .en_b(en_b1), .en_rem(en_rem1), .iter(iter1)
    );

    wire [6:0] ctl  = {sel_mux4, sel_mux3, en_a, en_b, en_rem};
    wire [6:0] ctl1 = {sel_mux4_1, sel_mux3_1, en_a1, en_b1, en_rem1};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] pk(input logic [1:0] m4, input logic [1:0] m3,
                                      input logic a, input logic b, input logic r);
        return {m4, m3, a, b, r};
    endfunction

    // Expected controls for cycle c after start is sampled, ITERS=6.
    function automatic logic [6:0] exp_ctl(input int c);
        if (c == 1)                 return pk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        if (c == 2)                 return pk(2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
        if (c >= 3 && c <= 14)      return (c % 2 == 1) ? pk(2'b10, 2'b01, 1'b1, 1'b0, 1'b0)
                                                        : pk(2'b11, 2'b01, 1'b0, 1'b1, 1'b0);
        if (c == 15)                return pk(2'b01, 2'b10, 1'b0, 1'b0, 1'b1);
        return 7'd0;
    endfunction

    function automatic logic [3:0] exp_iter(input int c);
        if (c >= 3 && c <= 14) return 4'((c - 3) / 2);
        if (c == 15 || c == 16) return 4'd6;
        return 4'd0;
    endfunction

    int done_cnt, done_at, done_at2;

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
`ifdef FPDIV_CTRL_ABORT_EN
        abort  = 1'b0;
`endif
        // Reset held for two edges with start high: must stay idle.
        start = 1'b1;
        step();
        step();
        chk("rst_ctl",  32'(ctl),  32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_iter", 32'(iter), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        start = 1'b0;
        reset = 1'b1;
        step();
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Nominal single-cycle start pulse, every cycle checked.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            chk($sformatf("nom_ctl_c%0d", c),  32'(ctl),  32'(exp_ctl(c)));
            chk($sformatf("nom_busy_c%0d", c), 32'(busy), 32'(c <= 16));
            chk($sformatf("nom_done_c%0d", c), 32'(done), 32'(c == 16));
            chk($sformatf("nom_iter_c%0d", c), 32'(iter), 32'(exp_iter(c)));
            chk($sformatf("nom_excl_c%0d", c), 32'(32'(en_a) + 32'(en_b) + 32'(en_rem) <= 1), 32'd1);
            step();
        end

        // start while busy (cycles 5 and 16) is ignored.
        start = 1'b1;
        step();
        done_cnt = 0;
        done_at  = 0;
        for (int c = 1; c <= 22; c++) begin
            if (done) begin
                done_cnt++;
                done_at = c;
            end
            if (c == 17) chk("busy_ign_idle17", 32'(busy), 32'd0);
            if (c == 18) chk("busy_ign_idle18", 32'(busy), 32'd0);
            start = (c == 5 || c == 16);
            step();
        end
        start = 1'b0;
        chk("busy_ign_done_cnt", 32'(done_cnt), 32'd1);
        chk("busy_ign_done_at",  32'(done_at),  32'd16);

        // Continuous start: back-to-back runs with one IDLE cycle between.
        start = 1'b1;
        step();
        done_cnt = 0;
        done_at  = 0;
        done_at2 = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) done_at = c;
                if (done_cnt == 2) done_at2 = c;
            end
            if (c == 17) chk("cont_idle17", 32'(busy), 32'd0);
            if (c == 18) chk("cont_load18", 32'(ctl), 32'(pk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0)));
            step();
        end
        start = 1'b0;
        chk("cont_done1", 32'(done_at),  32'd16);
        chk("cont_done2", 32'(done_at2), 32'd33);
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();

        // Reset mid-run at the edge ending cycle 8.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 8; c++) step();
        chk("mid_c8_ctl", 32'(ctl),  32'(exp_ctl(8)));
        chk("mid_c8_iter", 32'(iter), 32'd2);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mid_rst_ctl",  32'(ctl),  32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_iter", 32'(iter), 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (done || busy) done_cnt++;
            step();
        end
        chk("mid_rst_quiet", 32'(done_cnt), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        done_at = 0;
        for (int c = 1; c <= 20; c++) begin
            if (done && done_at == 0) done_at = c;
            step();
        end
        chk("mid_rst_fresh_done", 32'(done_at), 32'd16);

`ifdef FPDIV_CTRL_ABORT_EN
        // Abort during IT_B of iteration 3 (cycle 8).
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 8; c++) step();
        chk("abort_c8_ctl", 32'(ctl), 32'(exp_ctl(8)));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_iter", 32'(iter), 32'd0);
        chk("abort_ctl",  32'(ctl),  32'd0);
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) done_cnt++;
            step();
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        // abort together with start in IDLE: start wins.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_idle_start", 32'(busy), 32'd1);
        for (int c = 0; c < 20; c++) step();
`endif

        // ITERS=1 instance: REM at cycle 5, done at cycle 6.
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        done_at = 0;
        for (int c = 1; c <= 8; c++) begin
            if (done1 && done_at == 0) done_at = c;
            if (c == 4) chk("it1_itb_ctl", 32'(ctl1), 32'(pk(2'b11, 2'b01, 1'b0, 1'b1, 1'b0)));
            if (c == 5) chk("it1_rem_ctl", 32'(ctl1), 32'(pk(2'b01, 2'b10, 1'b0, 1'b0, 1'b1)));
            if (c == 5) chk("it1_rem_iter", 32'(iter1), 32'd1);
            if (c == 7) chk("it1_idle", 32'(busy1), 32'd0);
            step();
        end
        chk("it1_done_at", 32'(done_at), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
